// File: rtl/rv32i_types.sv
// Shared RV32I datapath types: load-extension select, LSU states,
// byte-enable encodings and the alignment check used by the LSU.
package rv32i_types;

   // Load extension select carried in the control word.
   typedef enum logic [2:0] {
      MDR_LW  = 3'b000,
      MDR_LH  = 3'b001,
      MDR_LHU = 3'b010,
      MDR_LB  = 3'b011,
      MDR_LBU = 3'b100
   } mdr_sel_t;

   // Load/store unit handshake states.
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } lsu_state_t;

   // Unshifted byte enables produced by the decoder.
   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

   // Halfwords must sit on an even address, words on a multiple of 4.
   function automatic logic misaligned(
      input logic [3:0] be,
      input logic [1:0] off
   );
      logic bad;
      bad = 1'b0;
      if (be == BE_HALF && off[0]) begin
         bad = 1'b1;
      end
      if (be == BE_WORD && off != 2'b00) begin
         bad = 1'b1;
      end
      return bad;
   endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the addressed lane down to bit 0 and
// applies sign or zero extension selected by mdr_sel.
module lsu_load_align
   import rv32i_types::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  mdr_sel_t    sel,
   output logic [31:0] data
);

   logic [31:0] shifted;

   // Bring the addressed byte/halfword down to the low lanes.
   always_comb begin
      shifted = word >> {offset, 3'b000};
   end

   // Extend according to the load type.
   always_comb begin
      data = shifted;
      unique case (sel)
         MDR_LW:  data = shifted;
         MDR_LH:  data = {{16{shifted[15]}}, shifted[15:0]};
         MDR_LHU: data = {16'h0000, shifted[15:0]};
         MDR_LB:  data = {{24{shifted[7]}}, shifted[7:0]};
         MDR_LBU: data = {24'h000000, shifted[7:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I memory-stage load/store unit with data-memory handshake.
// Optional watchdog on the memory access enabled by LSU_TIMEOUT_EN.
module load_store_unit
   import rv32i_types::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [3:0]        req_byte_enable,
   input  logic [2:0]        req_mdr_sel,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [3:0]        mem_byte_enable,
   input  logic              mem_resp,
   input  logic [DATA_W-1:0] mem_rdata
);

   if (DATA_W != 32 || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
      $error("load_store_unit: DATA_W must be 32, TIMEOUT_CYCLES >= 1");
   end

   lsu_state_t        state;
   lsu_state_t        state_n;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic [3:0]        be_q;
   mdr_sel_t          sel_q;
   logic              read_q;
   logic              err_q;
   logic              accept;
   logic              bad;
   logic              timeout;
   logic [31:0]       load_word;

   // A request is taken only in IDLE and only if it reads or writes.
   assign accept = (state == IDLE) && req_valid
                   && (req_read || req_write);

   // Rejected up front: misaligned, or both strobes requested at once.
   assign bad = (req_read && req_write)
                || misaligned(req_byte_enable, req_addr[1:0]);

`ifdef LSU_TIMEOUT_EN
   localparam int CNT_RAW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int CNT_W   = (CNT_RAW > 8) ? CNT_RAW : 8;

   logic [CNT_W-1:0] cnt_q;

   // Counts ACCESS cycles; cleared whenever the unit leaves ACCESS.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (state != ACCESS) begin
         cnt_q <= '0;
      end else if (!timeout) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // A response in the final cycle beats the watchdog.
   assign timeout = (state == ACCESS) && !mem_resp
                    && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state and handshake outputs toward the pipeline.
   always_comb begin
      state_n    = state;
      stall      = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = '0;
      unique case (state)
         IDLE: begin
            stall = accept;
            if (accept) begin
               state_n = bad ? DONE : ACCESS;
            end
         end
         ACCESS: begin
            stall = req_valid;
            if (mem_resp || timeout) begin
               state_n = DONE;
            end
         end
         DONE: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            if (read_q && !err_q) begin
               resp_rdata = load_word;
            end
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Request latch, registered strobes and read-data capture.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q    <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
         be_q      <= '0;
         sel_q     <= MDR_LW;
         read_q    <= 1'b0;
         err_q     <= 1'b0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
      end else if (accept) begin
         addr_q    <= req_addr;
         wdata_q   <= req_wdata;
         be_q      <= req_byte_enable;
         sel_q     <= mdr_sel_t'(req_mdr_sel);
         read_q    <= req_read;
         err_q     <= bad;
         rdata_q   <= '0;
         mem_read  <= req_read && !bad;
         mem_write <= req_write && !bad;
      end else if (state == ACCESS) begin
         if (mem_resp) begin
            rdata_q   <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end else if (timeout) begin
            err_q     <= 1'b1;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end
      end
   end

   // Memory-side address and lane-shifted store data.
   always_comb begin
      mem_address     = {addr_q[ADDR_W-1:2], 2'b00};
      mem_byte_enable = be_q << addr_q[1:0];
      mem_wdata       = wdata_q << {addr_q[1:0], 3'b000};
   end

   lsu_load_align u_align (
      .word   (rdata_q),
      .offset (addr_q[1:0]),
      .sel    (sel_q),
      .data   (load_word)
   );

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed accesses push the
// expected response; a negedge monitor pops it when resp_valid fires.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_read;
   logic        req_write;
   logic [3:0]  req_byte_enable;
   logic [2:0]  req_mdr_sel;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_read;
   logic        mem_write;
   logic [31:0] mem_address;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_byte_enable;
   logic        mem_resp;
   logic [31:0] mem_rdata;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks;
   int   errors;

   load_store_unit #(
      .ADDR_W         (32),
      .DATA_W         (32),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .req_valid       (req_valid),
      .req_read        (req_read),
      .req_write       (req_write),
      .req_byte_enable (req_byte_enable),
      .req_mdr_sel     (req_mdr_sel),
      .req_addr        (req_addr),
      .req_wdata       (req_wdata),
      .stall           (stall),
      .resp_valid      (resp_valid),
      .resp_rdata      (resp_rdata),
      .resp_err        (resp_err),
      .mem_read        (mem_read),
      .mem_write       (mem_write),
      .mem_address     (mem_address),
      .mem_wdata       (mem_wdata),
      .mem_byte_enable (mem_byte_enable),
      .mem_resp        (mem_resp),
      .mem_rdata       (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: every response must match the oldest expectation.
   always @(negedge clk) begin
      if (rst_n && resp_valid) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected resp_valid: rdata %h err %b",
                     resp_rdata, resp_err);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk({e.name, " rdata"}, resp_rdata, e.rdata);
            chk({e.name, " err"}, {31'd0, resp_err}, {31'd0, e.err});
         end
      end
   end

   task automatic access(
      input string       nm,
      input logic        rd,
      input logic        wr,
      input logic [3:0]  be,
      input logic [2:0]  sel,
      input logic [31:0] addr,
      input logic [31:0] wdata,
      input logic [31:0] rdata,
      input int          waits,
      input logic        xerr,
      input logic [31:0] xrdata,
      input logic [3:0]  xbe,
      input logic [31:0] xwdata
   );
      exp_t e;
      e.rdata = xrdata;
      e.err   = xerr;
      e.name  = nm;
      q.push_back(e);
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_read = rd;
      req_write = wr;
      req_byte_enable = be;
      req_mdr_sel = sel;
      req_addr = addr;
      req_wdata = wdata;
      @(negedge clk);
      chk({nm, " stall c0"}, {31'd0, stall}, 32'd1);
      chk({nm, " strobe c0"}, {30'd0, mem_read, mem_write}, 32'd0);
      @(posedge clk); #1;
      req_addr = 32'hDEAD_0003;
      req_wdata = 32'hFFFF_FFFF;
      req_byte_enable = 4'b0101;
      req_mdr_sel = 3'b111;
      if (!xerr) begin
         for (int c = 1; c <= 1 + waits; c++) begin
            if (c > 1) begin
               @(posedge clk); #1;
            end
            if (c == 1 + waits) begin
               mem_resp = 1'b1;
               mem_rdata = rdata;
            end
            @(negedge clk);
            chk({nm, " strobes"}, {30'd0, mem_read, mem_write},
                {30'd0, rd, wr});
            chk({nm, " addr"}, mem_address, {addr[31:2], 2'b00});
            chk({nm, " be"}, {28'd0, mem_byte_enable}, {28'd0, xbe});
            chk({nm, " wdata"}, mem_wdata, xwdata);
            chk({nm, " stall"}, {31'd0, stall}, 32'd1);
         end
         @(posedge clk); #1;
         mem_resp = 1'b0;
         mem_rdata = 32'h0BAD_F00D;
      end
      @(negedge clk);
      chk({nm, " resp_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({nm, " stall done"}, {31'd0, stall}, 32'd0);
      chk({nm, " strobe done"}, {30'd0, mem_read, mem_write}, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_read = 1'b0;
      req_write = 1'b0;
      @(negedge clk);
      chk({nm, " pulse"}, {31'd0, resp_valid}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      req_valid = 1'b0;
      req_read = 1'b0;
      req_write = 1'b0;
      req_byte_enable = 4'd0;
      req_mdr_sel = 3'd0;
      req_addr = 32'd0;
      req_wdata = 32'd0;
      mem_resp = 1'b0;
      mem_rdata = 32'd0;
      @(negedge clk);
      chk("reset outs", {28'd0, stall, resp_valid, mem_read, mem_write},
          32'd0);
      chk("reset addr", mem_address, 32'd0);
      chk("reset rdata", resp_rdata, 32'd0);
      chk("reset err", {31'd0, resp_err}, 32'd0);
      chk("reset be", {28'd0, mem_byte_enable}, 32'd0);
      chk("reset wdata", mem_wdata, 32'd0);
      #2 rst_n = 1'b1;

      access("LB 1003", 1, 0, 4'b0001, 3'b011, 32'h1003, 32'h0,
             32'h80FF_1234, 0, 0, 32'hFFFF_FF80, 4'b1000, 32'h0);
      access("SH 2002", 0, 1, 4'b0011, 3'b000, 32'h2002, 32'h0000_BEEF,
             32'hFFFF_FFFF, 3, 0, 32'h0, 4'b1100, 32'hBEEF_0000);
      access("LW 3001", 1, 0, 4'b1111, 3'b000, 32'h3001, 32'h0,
             32'h0, 0, 1, 32'h0, 4'b0000, 32'h0);
      access("LHU 4002", 1, 0, 4'b0011, 3'b010, 32'h4002, 32'h0,
             32'h8001_7FFF, 1, 0, 32'h0000_8001, 4'b1100, 32'h0);
      access("LH 0006", 1, 0, 4'b0011, 3'b001, 32'h0006, 32'h0,
             32'h8001_7FFF, 0, 0, 32'hFFFF_8001, 4'b1100, 32'h0);
      access("LBU 0001", 1, 0, 4'b0001, 3'b100, 32'h0001, 32'h0,
             32'h1234_56F0, 0, 0, 32'h0000_0056, 4'b0010, 32'h0);
      access("LW 0008", 1, 0, 4'b1111, 3'b000, 32'h0008, 32'h0,
             32'hDEAD_BEEF, 2, 0, 32'hDEAD_BEEF, 4'b1111, 32'h0);
      access("SB 0005", 0, 1, 4'b0001, 3'b000, 32'h0005, 32'h0000_00AB,
             32'h1111_1111, 0, 0, 32'h0, 4'b0010, 32'h0000_AB00);
      access("SW 0010", 0, 1, 4'b1111, 3'b000, 32'h0010, 32'h1122_3344,
             32'h0, 1, 0, 32'h0, 4'b1111, 32'h1122_3344);
      access("LH 0003", 1, 0, 4'b0011, 3'b001, 32'h0003, 32'h0,
             32'h0, 0, 1, 32'h0, 4'b0000, 32'h0);
      access("SW 0012", 0, 1, 4'b1111, 3'b000, 32'h0012, 32'h5555_5555,
             32'h0, 0, 1, 32'h0, 4'b0000, 32'h0);
      access("RW both", 1, 1, 4'b1111, 3'b000, 32'h0000, 32'h0,
             32'h0, 0, 1, 32'h0, 4'b0000, 32'h0);
      access("LB 0002", 1, 0, 4'b0001, 3'b011, 32'h0002, 32'h0,
             32'h007F_0000, 0, 0, 32'h0000_007F, 4'b0100, 32'h0);
      access("LW edge", 1, 0, 4'b1111, 3'b000, 32'h0020, 32'h0,
             32'hCAFE_0001, TO - 1, 0, 32'hCAFE_0001, 4'b1111, 32'h0);
`ifndef LSU_TIMEOUT_EN
      access("LW long", 1, 0, 4'b1111, 3'b000, 32'h0024, 32'h0,
             32'h0102_0304, 20, 0, 32'h0102_0304, 4'b1111, 32'h0);
`endif

      // No read or write: no stall and nothing starts.
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_addr = 32'h0040;
      req_byte_enable = 4'b1111;
      @(negedge clk);
      chk("nop stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("nop strobes", {30'd0, mem_read, mem_write}, 32'd0);
      chk("nop resp", {31'd0, resp_valid}, 32'd0);
      req_valid = 1'b0;

      // Reset in the middle of an access.
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_read = 1'b1;
      req_byte_enable = 4'b1111;
      req_mdr_sel = 3'b000;
      req_addr = 32'h5000;
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst pre rd", {31'd0, mem_read}, 32'd1);
      #1 rst_n = 1'b0;
      #1;
      chk("rst mem_read", {31'd0, mem_read}, 32'd0);
      chk("rst addr", mem_address, 32'd0);
      req_valid = 1'b0;
      req_read = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      mem_resp = 1'b1;
      mem_rdata = 32'h7777_7777;
      @(posedge clk); #1;
      mem_resp = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("late resp", {30'd0, resp_valid, mem_read}, 32'd0);
      end

`ifdef LSU_TIMEOUT_EN
      begin
         exp_t e;
         e.rdata = 32'h0;
         e.err = 1'b1;
         e.name = "timeout";
         q.push_back(e);
      end
      @(posedge clk); #1;
      req_valid = 1'b1;
      req_read = 1'b1;
      req_byte_enable = 4'b1111;
      req_addr = 32'h6000;
      @(posedge clk); #1;
      for (int c = 1; c <= TO; c++) begin
         @(negedge clk);
         chk("to strobe", {31'd0, mem_read}, 32'd1);
         chk("to no resp", {31'd0, resp_valid}, 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      chk("to resp_valid", {31'd0, resp_valid}, 32'd1);
      chk("to strobe low", {31'd0, mem_read}, 32'd0);
      @(posedge clk); #1;
      req_valid = 1'b0;
      req_read = 1'b0;
      @(negedge clk);
      chk("to after", {30'd0, resp_valid, mem_read}, 32'd0);
`endif

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("queue empty", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
